// File: rtl/ram_wb_arbiter.sv
// Two-master Wishbone arbiter sharing one RAM port between the bootloader (fixed priority) and the CPU.
// Define ARB_TIMEOUT_EN to add the stall watchdog and the ERR_WAIT state.
module ram_wb_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_boot_mode,
    input  logic                    i_boot_cyc,
    input  logic                    i_boot_stb,
    input  logic                    i_boot_we,
    input  logic [DATA_WIDTH/8-1:0] i_boot_sel,
    input  logic [ADDR_WIDTH-1:0]   i_boot_addr,
    input  logic [DATA_WIDTH-1:0]   i_boot_data,
    output logic                    o_boot_ack,
    output logic                    o_boot_err,
    output logic [DATA_WIDTH-1:0]   o_boot_data,
    input  logic                    i_cpu_cyc,
    input  logic                    i_cpu_stb,
    input  logic                    i_cpu_we,
    input  logic [DATA_WIDTH/8-1:0] i_cpu_sel,
    input  logic [ADDR_WIDTH-1:0]   i_cpu_addr,
    input  logic [DATA_WIDTH-1:0]   i_cpu_data,
    output logic                    o_cpu_ack,
    output logic                    o_cpu_err,
    output logic [DATA_WIDTH-1:0]   o_cpu_data,
    output logic                    o_ram_cyc,
    output logic                    o_ram_stb,
    output logic                    o_ram_we,
    output logic [DATA_WIDTH/8-1:0] o_ram_sel,
    output logic [ADDR_WIDTH-1:0]   o_ram_addr,
    output logic [DATA_WIDTH-1:0]   o_ram_data,
    input  logic                    i_ram_ack,
    input  logic [DATA_WIDTH-1:0]   i_ram_data,
    output logic [1:0]              o_grant
);

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_BOOT = 2'd1,
        GRANT_CPU  = 2'd2,
        ERR_WAIT   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_BOOT = 2'd1,
        GRANT_CPU  = 2'd2
    } state_t;
`endif

    state_t state, state_next;
    logic   boot_owned;
    logic   cpu_owned;
    logic   timeout;

    assign boot_owned  = (state == GRANT_BOOT);
    assign cpu_owned   = (state == GRANT_CPU);
    assign o_boot_data = i_ram_data;
    assign o_cpu_data  = i_ram_data;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_WIDTH = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_WIDTH-1:0] stall_cnt;
    logic                 err_boot;
    logic                 owner_cyc;
    logic                 err_owner_cyc;

    assign owner_cyc     = boot_owned ? i_boot_cyc : i_cpu_cyc;
    assign err_owner_cyc = err_boot ? i_boot_cyc : i_cpu_cyc;
    // Expiry only while the owner still holds cyc; a drop in the same cycle is a normal release.
    assign timeout    = (boot_owned || cpu_owned) && owner_cyc &&
                        (stall_cnt == CNT_WIDTH'(TIMEOUT_CYCLES));
    assign o_boot_err = boot_owned & timeout;
    assign o_cpu_err  = cpu_owned & timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            err_boot  <= 1'b0;
        end else begin
            if (!(boot_owned || cpu_owned) || i_ram_ack) begin
                stall_cnt <= '0;
            end else if (o_ram_stb) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (timeout) begin
                err_boot <= boot_owned;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
    assign o_boot_err = 1'b0;
    assign o_cpu_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        o_ram_cyc  = 1'b0;
        o_ram_stb  = 1'b0;
        o_ram_we   = 1'b0;
        o_ram_sel  = '0;
        o_ram_addr = '0;
        o_ram_data = '0;
        o_boot_ack = 1'b0;
        o_cpu_ack  = 1'b0;
        o_grant    = 2'b00;
        case (state)
            IDLE: begin
                if (i_boot_cyc) begin
                    state_next = GRANT_BOOT;
                end else if (i_cpu_cyc && !i_boot_mode) begin
                    state_next = GRANT_CPU;
                end
            end
            GRANT_BOOT: begin
                o_grant    = 2'b10;
                o_ram_cyc  = i_boot_cyc & ~timeout;
                o_ram_stb  = i_boot_stb & ~timeout;
                o_ram_we   = i_boot_we;
                o_ram_sel  = i_boot_sel;
                o_ram_addr = i_boot_addr;
                o_ram_data = i_boot_data;
                o_boot_ack = i_boot_stb & i_ram_ack & ~timeout;
                if (!i_boot_cyc) begin
                    state_next = IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (timeout) begin
                    state_next = ERR_WAIT;
`endif
                end
            end
            GRANT_CPU: begin
                o_grant    = 2'b01;
                o_ram_cyc  = i_cpu_cyc & ~timeout;
                o_ram_stb  = i_cpu_stb & ~timeout;
                o_ram_we   = i_cpu_we;
                o_ram_sel  = i_cpu_sel;
                o_ram_addr = i_cpu_addr;
                o_ram_data = i_cpu_data;
                o_cpu_ack  = i_cpu_stb & i_ram_ack & ~timeout;
                if (!i_cpu_cyc) begin
                    state_next = IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (timeout) begin
                    state_next = ERR_WAIT;
`endif
                end
            end
`ifdef ARB_TIMEOUT_EN
            ERR_WAIT: begin
                if (!err_owner_cyc) begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Bench for ram_wb_arbiter: directed scenarios plus random traffic against an ownership-level reference model.
module tb_ram_wb_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int TMO  = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          boot_mode;
    logic          boot_cyc, boot_stb, boot_we;
    logic [SW-1:0] boot_sel;
    logic [AW-1:0] boot_addr;
    logic [DW-1:0] boot_wdata;
    logic          boot_ack, boot_err;
    logic [DW-1:0] boot_rdata;
    logic          cpu_cyc, cpu_stb, cpu_we;
    logic [SW-1:0] cpu_sel;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack, cpu_err;
    logic [DW-1:0] cpu_rdata;
    logic          ram_cyc, ram_stb, ram_we;
    logic [SW-1:0] ram_sel;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ack;
    logic [DW-1:0] ram_rdata;
    logic [1:0]    grant;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the port (0 none, 1 cpu, 2 boot), watchdog-terminated flag, stall count.
    int m_owner;
    bit m_errwait;
    int m_cnt;

    always #5 clk = ~clk;

    ram_wb_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_boot_mode (boot_mode),
        .i_boot_cyc  (boot_cyc),
        .i_boot_stb  (boot_stb),
        .i_boot_we   (boot_we),
        .i_boot_sel  (boot_sel),
        .i_boot_addr (boot_addr),
        .i_boot_data (boot_wdata),
        .o_boot_ack  (boot_ack),
        .o_boot_err  (boot_err),
        .o_boot_data (boot_rdata),
        .i_cpu_cyc   (cpu_cyc),
        .i_cpu_stb   (cpu_stb),
        .i_cpu_we    (cpu_we),
        .i_cpu_sel   (cpu_sel),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_data  (cpu_wdata),
        .o_cpu_ack   (cpu_ack),
        .o_cpu_err   (cpu_err),
        .o_cpu_data  (cpu_rdata),
        .o_ram_cyc   (ram_cyc),
        .o_ram_stb   (ram_stb),
        .o_ram_we    (ram_we),
        .o_ram_sel   (ram_sel),
        .o_ram_addr  (ram_addr),
        .o_ram_data  (ram_wdata),
        .i_ram_ack   (ram_ack),
        .i_ram_data  (ram_rdata),
        .o_grant     (grant)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit own_cyc();
        return (m_owner == 2) ? boot_cyc : (m_owner == 1) ? cpu_cyc : 1'b0;
    endfunction

    function automatic bit own_stb();
        return (m_owner == 2) ? boot_stb : (m_owner == 1) ? cpu_stb : 1'b0;
    endfunction

    function automatic bit expiry();
        return TMO_EN && (m_owner != 0) && !m_errwait && own_cyc() && (m_cnt == TMO);
    endfunction

    task automatic model_reset();
        m_owner   = 0;
        m_errwait = 1'b0;
        m_cnt     = 0;
    endtask

    // Applies the ownership rules for one rising edge using the inputs held across it.
    task automatic model_update();
        bit ex;
        ex = expiry();
        if (reset) begin
            model_reset();
        end else if (m_errwait) begin
            if (!own_cyc()) begin
                m_owner   = 0;
                m_errwait = 1'b0;
                m_cnt     = 0;
            end
        end else if (m_owner == 0) begin
            m_cnt = 0;
            if (boot_cyc) m_owner = 2;
            else if (cpu_cyc && !boot_mode) m_owner = 1;
        end else begin
            if (!own_cyc()) begin
                m_owner = 0;
                m_cnt   = 0;
            end else if (ex) begin
                m_errwait = 1'b1;
            end else if (ram_ack) begin
                m_cnt = 0;
            end else if (own_stb()) begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_all();
        bit bo, co, ex;
        bo = (m_owner == 2) && !m_errwait;
        co = (m_owner == 1) && !m_errwait;
        ex = expiry();
        chk("ram_cyc", ram_cyc, ((bo && boot_cyc) || (co && cpu_cyc)) && !ex);
        chk("ram_stb", ram_stb, ((bo && boot_stb) || (co && cpu_stb)) && !ex);
        chk("ram_we", ram_we, bo ? boot_we : co ? cpu_we : 1'b0);
        chk("ram_sel", ram_sel, bo ? boot_sel : co ? cpu_sel : '0);
        chk("ram_addr", ram_addr, bo ? boot_addr : co ? cpu_addr : '0);
        chk("ram_data", ram_wdata, bo ? boot_wdata : co ? cpu_wdata : '0);
        chk("boot_ack", boot_ack, bo && boot_stb && ram_ack && !ex);
        chk("cpu_ack", cpu_ack, co && cpu_stb && ram_ack && !ex);
        chk("boot_err", boot_err, bo && ex);
        chk("cpu_err", cpu_err, co && ex);
        chk("grant", grant, bo ? 2'b10 : co ? 2'b01 : 2'b00);
        chk("boot_rdata", boot_rdata, ram_rdata);
        chk("cpu_rdata", cpu_rdata, ram_rdata);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        boot_cyc = 0; boot_stb = 0; boot_we = 0; boot_sel = '0; boot_addr = '0; boot_wdata = '0;
        cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cpu_sel = '0; cpu_addr = '0; cpu_wdata = '0;
        ram_ack = 0; ram_rdata = '0; boot_mode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int errs;
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #2;
        chk("rst_grant", grant, 2'b00);
        chk("rst_ram_cyc", ram_cyc, 1'b0);
        chk("rst_acks", {boot_ack, cpu_ack, boot_err, cpu_err}, 4'b0);
        step();
        step();
        reset = 1'b0;
        step();

        // CPU single write
        cpu_cyc = 1; cpu_stb = 1; cpu_we = 1; cpu_sel = 4'hF;
        cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        #1 chk("t1_pre_grant", grant, 2'b00);
        step();
        chk("t1_grant", grant, 2'b01);
        chk("t1_addr", ram_addr, 32'h10);
        chk("t1_data", ram_wdata, 32'hDEADBEEF);
        chk("t1_we", ram_we, 1'b1);
        chk("t1_noack", cpu_ack, 1'b0);
        ram_ack = 1; ram_rdata = 32'h1234_5678;
        #1 chk("t1_ack", cpu_ack, 1'b1);
        step();
        cpu_cyc = 0; cpu_stb = 0; ram_ack = 0;
        step();
        chk("t1_release", grant, 2'b00);

        // Simultaneous request: bootloader wins, CPU waits one IDLE cycle after release
        boot_cyc = 1; boot_stb = 1; boot_addr = 32'h200;
        cpu_cyc = 1; cpu_stb = 1; cpu_we = 0;
        step();
        chk("t2_boot_first", grant, 2'b10);
        ram_ack = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t2_cpu_noack", cpu_ack, 1'b0);
            step();
        end
        boot_cyc = 0; boot_stb = 0; ram_ack = 0;
        step();
        chk("t2_gap", grant, 2'b00);
        step();
        chk("t2_cpu_after", grant, 2'b01);
        cpu_cyc = 0; cpu_stb = 0;
        step();

        // Boot mode locks the CPU out
        boot_mode = 1; cpu_cyc = 1; cpu_stb = 1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("t3_locked", grant, 2'b00);
        end
        boot_mode = 0;
        step();
        chk("t3_unlocked", grant, 2'b01);
        cpu_cyc = 0; cpu_stb = 0;
        step();

        // CPU 4-beat burst is not preempted
        cpu_cyc = 1; cpu_stb = 1;
        step();
        chk("t4_grant", grant, 2'b01);
        ram_ack = 1; boot_cyc = 1; boot_stb = 1;
        for (int b = 0; b < 4; b++) begin
            #1 chk("t4_beat_ack", cpu_ack, 1'b1);
            chk("t4_beat_grant", grant, 2'b01);
            chk("t4_boot_noack", boot_ack, 1'b0);
            step();
        end
        cpu_cyc = 0; cpu_stb = 0; ram_ack = 0;
        step();
        chk("t4_gap", grant, 2'b00);
        step();
        chk("t4_boot_grant", grant, 2'b10);

        // Asynchronous reset in the middle of a granted cycle
        ram_ack = 1;
        #2 reset = 1;
        model_reset();
        #1;
        chk("t5_grant", grant, 2'b00);
        chk("t5_ram_cyc", ram_cyc, 1'b0);
        chk("t5_ack", boot_ack, 1'b0);
        idle_inputs();
        step();
        reset = 0;
        step();

        // Stalled slave
        boot_cyc = 1; boot_stb = 1; ram_ack = 0;
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (boot_err) errs++;
        end
`ifdef ARB_TIMEOUT_EN
        chk("t6_err_pulses", errs, 1);
        chk("t6_ram_cyc", ram_cyc, 1'b0);
        boot_cyc = 0; boot_stb = 0;
        step();
        chk("t6_idle", grant, 2'b00);
`else
        chk("t6_err_pulses", errs, 0);
        chk("t6_hold", grant, 2'b10);
        chk("t6_ram_cyc", ram_cyc, 1'b1);
        boot_cyc = 0; boot_stb = 0;
        step();
        chk("t6_idle", grant, 2'b00);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (reset) reset = 0;
            else if ($urandom_range(0, 499) == 0) begin
                reset = 1;
                model_reset();
            end
            if ($urandom_range(0, 7) == 0) boot_cyc = ~boot_cyc;
            if ($urandom_range(0, 5) == 0) cpu_cyc = ~cpu_cyc;
            if ($urandom_range(0, 39) == 0) boot_mode = ~boot_mode;
            boot_stb   = boot_cyc & ($urandom_range(0, 3) != 0);
            cpu_stb    = cpu_cyc & ($urandom_range(0, 3) != 0);
            boot_we    = 1'($urandom);
            cpu_we     = 1'($urandom);
            boot_sel   = SW'($urandom);
            cpu_sel    = SW'($urandom);
            boot_addr  = $urandom;
            cpu_addr   = $urandom;
            boot_wdata = $urandom;
            cpu_wdata  = $urandom;
            ram_ack    = 1'($urandom);
            ram_rdata  = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
